// File: rtl/adder_share_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_seq_pkg
// Brief    : Shared constants and state encoding for the adder sharing
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package adder_share_seq_pkg;

    // Width of the shared combinational adder; wide operands are twice this.
    localparam int c_W = 8;

    // Increment applied when propagating the low-byte carry into the high byte.
    localparam logic [c_W-1:0] c_BYTE_ONE = 8'h01;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LO       = 3'd1,
        ST_HI       = 3'd2,
        ST_HI_CARRY = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage : adder_share_seq_pkg
`default_nettype wire

// File: rtl/adder_share_seq_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant. When both requesters are valid the
//            one that did not win last time is chosen. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import adder_share_seq_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Single requester wins outright; a tie goes to the one not served last.
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/adder_share_seq.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_seq
// Brief    : Shares one external W-bit adder between two requesters. Narrow
//            adds take one pass, wide adds take a low pass, a high pass and,
//            if the low byte overflowed, a carry-increment pass.
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_seq
    import adder_share_seq_pkg::*;
#(
    parameter int W = c_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_wide,
    input  logic [2*W-1:0] req0_a,
    input  logic [2*W-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_wide,
    input  logic [2*W-1:0] req1_a,
    input  logic [2*W-1:0] req1_b,
    output logic [W-1:0]   adder_a,
    output logic [W-1:0]   adder_b,
    input  logic [W-1:0]   adder_sum,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_carry,
    output logic           busy
);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant;
    logic           r_id;
    logic           r_wide;
    logic [2*W-1:0] r_a;
    logic [2*W-1:0] r_b;
    logic [W-1:0]   r_res_lo;
    logic [W-1:0]   r_res_hi;
    logic           r_c_lo;
    logic           r_c_hi;
    logic           r_carry;
    logic           w_grant_valid;
    logic           w_grant_id;
    logic           w_ovf;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // An unsigned add wrapped exactly when the sum is below either operand.
    assign w_ovf = (adder_sum < adder_a);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, grant handshake and adder operand selection.
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        adder_a      = '0;
        adder_b      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    req0_ready   = ~w_grant_id;
                    req1_ready   = w_grant_id;
                    w_next_state = ST_LO;
                end
            end
            ST_LO: begin
                adder_a      = r_a[W-1:0];
                adder_b      = r_b[W-1:0];
                w_next_state = r_wide ? ST_HI : ST_DONE;
            end
            ST_HI: begin
                adder_a      = r_a[2*W-1:W];
                adder_b      = r_b[2*W-1:W];
                w_next_state = r_c_lo ? ST_HI_CARRY : ST_DONE;
            end
            ST_HI_CARRY: begin
                adder_a      = r_res_hi;
                adder_b      = c_BYTE_ONE;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance and per-pass result/carry accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_wide       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_res_lo     <= '0;
            r_res_hi     <= '0;
            r_c_lo       <= 1'b0;
            r_c_hi       <= 1'b0;
            r_carry      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_wide       <= w_grant_id ? req1_wide : req0_wide;
                        r_a          <= w_grant_id ? req1_a : req0_a;
                        r_b          <= w_grant_id ? req1_b : req0_b;
                    end
                end
                ST_LO: begin
                    r_res_lo <= adder_sum;
                    r_c_lo   <= w_ovf;
                    if (!r_wide) begin
                        r_res_hi <= '0;
                        r_carry  <= w_ovf;
                    end
                end
                ST_HI: begin
                    r_res_hi <= adder_sum;
                    r_c_hi   <= w_ovf;
                    r_carry  <= w_ovf;
                end
                ST_HI_CARRY: begin
                    // Incrementing 0xFF wraps to zero, which is the only way
                    // the low carry can ripple out of the top byte.
                    r_res_hi <= adder_sum;
                    r_carry  <= r_c_hi | (adder_sum == '0);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = (r_state == ST_DONE);
    assign rsp_id     = r_id;
    assign rsp_result = {r_res_hi, r_res_lo};
    assign rsp_carry  = r_carry;
    assign busy       = (r_state != ST_IDLE);

endmodule : adder_share_seq
`default_nettype wire
